// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the matrix-keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_PEND   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_PEND = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } kp_frame_t;

    // Index width that never collapses to zero bits.
    function automatic int kp_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int kp_code_width(input int rows, input int cols);
        return kp_idx_width(rows * cols);
    endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Frame-level press/release debouncer; turns per-frame key classification
// into one-cycle press/release events and a latched key identity.
module keypad_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CW       = 4,
    parameter int RW       = 2,
    parameter int CLW      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_frame_end,
    input  kp_frame_t       i_frame_class,
    input  logic [CW-1:0]   i_frame_code,
    input  logic [RW-1:0]   i_frame_row,
    input  logic [CLW-1:0]  i_frame_col,
    output logic            o_key_press,
    output logic            o_key_release,
    output logic            o_key_held,
    output logic [CW-1:0]   o_key_code,
    output logic [RW-1:0]   o_key_row,
    output logic [CLW-1:0]  o_key_col
);

    localparam int DW = kp_idx_width(DEBOUNCE + 1);

    kp_state_t        r_state;
    logic [DW-1:0]    r_cnt;
    logic [CW-1:0]    r_cand_code;
    logic [RW-1:0]    r_cand_row;
    logic [CLW-1:0]   r_cand_col;
    logic [CW-1:0]    r_key_code;
    logic [RW-1:0]    r_key_row;
    logic [CLW-1:0]   r_key_col;
    logic             r_press;
    logic             r_release;

    kp_state_t        w_state_nxt;
    logic [DW-1:0]    w_cnt_nxt;
    logic             w_load_cand;
    logic             w_accept_press;
    logic             w_accept_release;
    logic             w_single;
    logic             w_match_cand;
    logic             w_match_key;

    assign w_single     = (i_frame_class == FR_SINGLE);
    assign w_match_cand = w_single && (i_frame_code == r_cand_code);
    assign w_match_key  = w_single && (i_frame_code == r_key_code);

    // NOTE: combinational next-state uses blocking assignments and gives every
    // output a default first, so no path leaves a value held (no latch).
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_load_cand      = 1'b0;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        if (i_frame_end) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_single) begin
                        w_load_cand = 1'b1;
                        w_cnt_nxt   = DW'(1);
                        w_state_nxt = ST_PRESS_PEND;
                    end
                end
                ST_PRESS_PEND: begin
                    if (w_match_cand) begin
                        w_cnt_nxt = r_cnt + DW'(1);
                    end else if (w_single) begin
                        w_load_cand = 1'b1;
                        w_cnt_nxt   = DW'(1);
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_RELEASED;
                    end
                end
                ST_PRESSED: begin
                    if (!w_match_key) begin
                        w_cnt_nxt   = DW'(1);
                        w_state_nxt = ST_RELEASE_PEND;
                    end
                end
                ST_RELEASE_PEND: begin
                    if (w_match_key) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_PRESSED;
                    end else begin
                        w_cnt_nxt = r_cnt + DW'(1);
                    end
                end
                default: w_state_nxt = ST_RELEASED;
            endcase

            // A pending state whose count reaches DEBOUNCE is accepted at once,
            // which also gives the direct transitions when DEBOUNCE is 1.
            if (w_cnt_nxt == DW'(DEBOUNCE)) begin
                if (w_state_nxt == ST_PRESS_PEND) begin
                    w_accept_press = 1'b1;
                    w_state_nxt    = ST_PRESSED;
                    w_cnt_nxt      = '0;
                end else if (w_state_nxt == ST_RELEASE_PEND) begin
                    w_accept_release = 1'b1;
                    w_state_nxt      = ST_RELEASED;
                    w_cnt_nxt        = '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RELEASED;
            r_cnt       <= '0;
            r_cand_code <= '0;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_key_code  <= '0;
            r_key_row   <= '0;
            r_key_col   <= '0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_accept_press;
            r_release <= w_accept_release;
            if (w_load_cand) begin
                r_cand_code <= i_frame_code;
                r_cand_row  <= i_frame_row;
                r_cand_col  <= i_frame_col;
            end
            if (w_accept_press) begin
                r_key_code <= w_load_cand ? i_frame_code : r_cand_code;
                r_key_row  <= w_load_cand ? i_frame_row  : r_cand_row;
                r_key_col  <= w_load_cand ? i_frame_col  : r_cand_col;
            end
        end
    end

    assign o_key_press   = r_press;
    assign o_key_release = r_release;
    assign o_key_held    = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_PEND);
    assign o_key_code    = r_key_code;
    assign o_key_row     = r_key_row;
    assign o_key_col     = r_key_col;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: column drive, row synchroniser, per-frame hit
// accumulation and classification feeding the debounce FSM.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 4,
    parameter  int SCAN_DIV = 100000,
    parameter  int DEBOUNCE = 3,
    localparam int CW       = kp_code_width(ROWS, COLS),
    localparam int RW       = kp_idx_width(ROWS),
    localparam int CLW      = kp_idx_width(COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [CW-1:0]   key_code,
    output logic [RW-1:0]   key_row,
    output logic [CLW-1:0]  key_col,
    output logic            key_press,
    output logic            key_release,
    output logic            key_held,
    output logic            multi_key
);

    localparam int SDW = kp_idx_width(SCAN_DIV);

    logic [ROWS-1:0] r_row_meta;
    logic [ROWS-1:0] r_row_sync;
    logic [SDW-1:0]  r_slot;
    logic [CLW-1:0]  r_col_idx;
    logic [1:0]      r_hits;
    logic [CW-1:0]   r_first_code;
    logic [RW-1:0]   r_first_row;
    logic [CLW-1:0]  r_first_col;
    logic            r_frame_end;
    kp_frame_t       r_frame_class;
    logic [CW-1:0]   r_frame_code;
    logic [RW-1:0]   r_frame_row;
    logic [CLW-1:0]  r_frame_col;
    logic            r_multi;

    logic            w_sample;
    logic            w_last_col;
    logic [1:0]      w_col_hits;
    logic            w_col_found;
    logic [RW-1:0]   w_col_row;
    logic [CW-1:0]   w_col_code;
    logic [2:0]      w_sum;
    logic [1:0]      w_tot;
    logic            w_take;
    logic [CW-1:0]   w_acc_code;
    logic [RW-1:0]   w_acc_row;
    logic [CLW-1:0]  w_acc_col;
    kp_frame_t       w_class;

    assign w_sample   = (r_slot == SDW'(SCAN_DIV - 1));
    assign w_last_col = (r_col_idx == CLW'(COLS - 1));
    assign col        = ~(COLS'(1) << r_col_idx);

    // Hits in the current column (saturating at two) and its lowest hit row.
    always_comb begin
        w_col_hits  = 2'd0;
        w_col_found = 1'b0;
        w_col_row   = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!r_row_sync[r]) begin
                w_col_found = 1'b1;
                w_col_row   = RW'(r);
                if (w_col_hits != 2'd2) w_col_hits = w_col_hits + 2'd1;
            end
        end
    end

    assign w_col_code = CW'(int'(w_col_row) * COLS + int'(r_col_idx));
    assign w_sum      = {1'b0, r_hits} + {1'b0, w_col_hits};
    assign w_tot      = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    assign w_take     = w_col_found && ((r_hits == 2'd0) || (w_col_code < r_first_code));
    assign w_acc_code = w_take ? w_col_code : r_first_code;
    assign w_acc_row  = w_take ? w_col_row  : r_first_row;
    assign w_acc_col  = w_take ? r_col_idx  : r_first_col;
    assign w_class    = (w_tot == 2'd0) ? FR_NONE :
                        (w_tot == 2'd1) ? FR_SINGLE : FR_MULTI;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta    <= '1;
            r_row_sync    <= '1;
            r_slot        <= '0;
            r_col_idx     <= '0;
            r_hits        <= 2'd0;
            r_first_code  <= '0;
            r_first_row   <= '0;
            r_first_col   <= '0;
            r_frame_end   <= 1'b0;
            r_frame_class <= FR_NONE;
            r_frame_code  <= '0;
            r_frame_row   <= '0;
            r_frame_col   <= '0;
            r_multi       <= 1'b0;
        end else begin
            r_row_meta  <= row;
            r_row_sync  <= r_row_meta;
            r_frame_end <= 1'b0;
            if (w_sample) begin
                r_slot    <= '0;
                r_col_idx <= w_last_col ? '0 : r_col_idx + CLW'(1);
                if (w_last_col) begin
                    r_frame_end   <= 1'b1;
                    r_frame_class <= w_class;
                    r_frame_code  <= w_acc_code;
                    r_frame_row   <= w_acc_row;
                    r_frame_col   <= w_acc_col;
                    r_hits        <= 2'd0;
                    r_first_code  <= '0;
                    r_first_row   <= '0;
                    r_first_col   <= '0;
                end else begin
                    r_hits       <= w_tot;
                    r_first_code <= w_acc_code;
                    r_first_row  <= w_acc_row;
                    r_first_col  <= w_acc_col;
                end
            end else begin
                r_slot <= r_slot + SDW'(1);
            end
            if (r_frame_end) r_multi <= (r_frame_class == FR_MULTI);
        end
    end

    keypad_debounce_fsm #(
        .DEBOUNCE (DEBOUNCE),
        .CW       (CW),
        .RW       (RW),
        .CLW      (CLW)
    ) u_fsm (
        .clk           (clk),
        .rst           (rst),
        .i_frame_end   (r_frame_end),
        .i_frame_class (r_frame_class),
        .i_frame_code  (r_frame_code),
        .i_frame_row   (r_frame_row),
        .i_frame_col   (r_frame_col),
        .o_key_press   (key_press),
        .o_key_release (key_release),
        .o_key_held    (key_held),
        .o_key_code    (key_code),
        .o_key_row     (key_row),
        .o_key_col     (key_col)
    );

    assign multi_key = r_multi;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Frame-level bench for keypad_scan_ctrl: a keypad matrix model, a table of
// per-frame key sets with expected outputs, and hand-written reset sequences.
module tb_keypad_scan_ctrl;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 8;
    localparam int DEBOUNCE = 3;
    localparam int FRAME    = COLS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic [1:0]  key_row;
    logic [1:0]  key_col;
    logic        key_press;
    logic        key_release;
    logic        key_held;
    logic        multi_key;
    logic [15:0] keys_q = '0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .key_code    (key_code),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_press   (key_press),
        .key_release (key_release),
        .key_held    (key_held),
        .multi_key   (multi_key)
    );

    // Pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (keys_q[r*COLS + c] && !col[c]) row[r] = 1'b0;
    end

    typedef struct {
        int          idx;
        logic [15:0] keys;
        logic        prs;
        logic        rls;
        int          code;
        logic        held;
        logic        multi;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] k1(input int code);
        logic [15:0] one;
        one = 16'd1;
        return one << code;
    endfunction

    task automatic add(input logic [15:0] keys, input logic prs, input logic rls,
                       input int code, input logic held, input logic multi);
        vec_t e;
        e.idx = vecs.size(); e.keys = keys; e.prs = prs; e.rls = rls;
        e.code = code; e.held = held; e.multi = multi;
        vecs.push_back(e);
    endtask

    task automatic compare_out(input vec_t e);
        check($sformatf("f%0d key_press", e.idx), key_press, e.prs);
        check($sformatf("f%0d key_release", e.idx), key_release, e.rls);
        check($sformatf("f%0d key_code", e.idx), key_code, e.code);
        check($sformatf("f%0d key_row", e.idx), key_row, e.code / COLS);
        check($sformatf("f%0d key_col", e.idx), key_col, e.code % COLS);
        check($sformatf("f%0d key_held", e.idx), key_held, e.held);
        check($sformatf("f%0d multi_key", e.idx), multi_key, e.multi);
    endtask

    // Called #1 after a frame-boundary edge. The previous frame's decision
    // appears on the first edge of this window; any other pulse is stray.
    task automatic run_frame(input vec_t e);
        int stray;
        stray  = 0;
        keys_q = e.keys;
        exp_q.push_back(e);
        for (int kk = 1; kk <= FRAME; kk++) begin
            @(posedge clk); #1;
            if (kk == 1 && exp_q.size() > 1) compare_out(exp_q.pop_front());
            else if (key_press || key_release) stray++;
            if (kk % SCAN_DIV == 4)
                check("col_scan", col, (~(1 << ((kk % FRAME) / SCAN_DIV))) & 15);
        end
        check($sformatf("f%0d stray_pulse", e.idx), stray, 0);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        if (exp_q.size() > 0) compare_out(exp_q.pop_front());
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " key_press"}, key_press, 0);
        check({tag, " key_release"}, key_release, 0);
        check({tag, " key_held"}, key_held, 0);
        check({tag, " multi_key"}, multi_key, 0);
        check({tag, " key_code"}, key_code, 0);
        check({tag, " key_row"}, key_row, 0);
        check({tag, " key_col"}, key_col, 0);
        check({tag, " col"}, col, 4'b1110);
    endtask

    initial begin
        // Single press of key 9 (row 2, col 1), held 5 frames.
        add(k1(9), 0, 0, 0, 0, 0);
        add(k1(9), 0, 0, 0, 0, 0);
        add(k1(9), 1, 0, 9, 1, 0);
        add(k1(9), 0, 0, 9, 1, 0);
        add(k1(9), 0, 0, 9, 1, 0);
        // Release with a one-frame re-assertion bounce.
        add(16'h0, 0, 0, 9, 1, 0);
        add(k1(9), 0, 0, 9, 1, 0);
        add(16'h0, 0, 0, 9, 1, 0);
        add(16'h0, 0, 0, 9, 1, 0);
        add(16'h0, 0, 1, 9, 0, 0);
        add(16'h0, 0, 0, 9, 0, 0);
        // Press bounce: 2 frames, gap, 3 frames.
        add(k1(9), 0, 0, 9, 0, 0);
        add(k1(9), 0, 0, 9, 0, 0);
        add(16'h0, 0, 0, 9, 0, 0);
        add(k1(9), 0, 0, 9, 0, 0);
        add(k1(9), 0, 0, 9, 0, 0);
        add(k1(9), 1, 0, 9, 1, 0);
        add(16'h0, 0, 0, 9, 1, 0);
        add(16'h0, 0, 0, 9, 1, 0);
        add(16'h0, 0, 1, 9, 0, 0);
        // Multi-key 0+5, then 5 dropped.
        add(k1(0) | k1(5), 0, 0, 9, 0, 1);
        add(k1(0) | k1(5), 0, 0, 9, 0, 1);
        add(k1(0), 0, 0, 9, 0, 0);
        add(k1(0), 0, 0, 9, 0, 0);
        add(k1(0), 1, 0, 0, 1, 0);
        // Roll 0 -> 3, then the rollover 3 -> 12.
        add(k1(3), 0, 0, 0, 1, 0);
        add(k1(3), 0, 0, 0, 1, 0);
        add(k1(3), 0, 1, 0, 0, 0);
        add(k1(3), 0, 0, 0, 0, 0);
        add(k1(3), 0, 0, 0, 0, 0);
        add(k1(3), 1, 0, 3, 1, 0);
        add(k1(12), 0, 0, 3, 1, 0);
        add(k1(12), 0, 0, 3, 1, 0);
        add(k1(12), 0, 1, 3, 0, 0);
        add(k1(12), 0, 0, 3, 0, 0);
        add(k1(12), 0, 0, 3, 0, 0);
        add(k1(12), 1, 0, 12, 1, 0);
        // Release 12; candidate changes 6 -> 7 while pending.
        add(16'h0, 0, 0, 12, 1, 0);
        add(16'h0, 0, 0, 12, 1, 0);
        add(16'h0, 0, 1, 12, 0, 0);
        add(k1(6), 0, 0, 12, 0, 0);
        add(k1(7), 0, 0, 12, 0, 0);
        add(k1(7), 0, 0, 12, 0, 0);
        add(k1(7), 1, 0, 7, 1, 0);
        // Roll 7 -> 9 and leave 9 held for the reset test.
        add(k1(9), 0, 0, 7, 1, 0);
        add(k1(9), 0, 0, 7, 1, 0);
        add(k1(9), 0, 1, 7, 0, 0);
        add(k1(9), 0, 0, 7, 0, 0);
        add(k1(9), 0, 0, 7, 0, 0);
        add(k1(9), 1, 0, 9, 1, 0);
        add(k1(9), 0, 0, 9, 1, 0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        foreach (vecs[i]) run_frame(vecs[i]);
        drain();

        // Reset mid-frame while key 9 is held.
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst key_held", key_held, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_rst");
        @(posedge clk); #1;
        check("mid_rst2 key_release", key_release, 0);
        rst = 1'b0;

        vecs.delete();
        add(k1(9), 0, 0, 0, 0, 0);
        add(k1(9), 0, 0, 0, 0, 0);
        add(k1(9), 1, 0, 9, 1, 0);
        add(k1(9), 0, 0, 9, 1, 0);
        foreach (vecs[i]) run_frame(vecs[i]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner for the calculator front end, the successor to the original fixed 4x4 scanner. It drives one active-low column at a time, synchronises and samples the rows, and classifies each full scan frame as no key, a single key or multiple keys. A press/release debounce state machine then emits one-cycle `key_press`/`key_release` events carrying a linear key code. Downstream calculator logic consumes events only; it never looks at raw rows.

## Interface
- `ROWS`, 4: number of row inputs (2..8).
- `COLS`, 4: number of column outputs (2..8).
- `SCAN_DIV`, 100000: clock cycles each column is driven (>= 4).
- `DEBOUNCE`, 3: consecutive agreeing frames needed to accept a press or release (>= 1).
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high; the design has one clock.
- `row` in ROWS: raw row inputs, active-low, asynchronous.
- `col` out COLS: active-low one-hot column drive.
- `key_code` out CW=$clog2(ROWS*COLS): `row_idx*COLS + col_idx` of the accepted key.
- `key_row` out $clog2(ROWS): row index of the accepted key.
- `key_col` out $clog2(COLS): column index of the accepted key.
- `key_press` out 1: one-cycle pulse when a press is accepted.
- `key_release` out 1: one-cycle pulse when a release is accepted.
- `key_held` out 1: high while the FSM is in PRESSED or RELEASE_PEND.
- `multi_key` out 1: high if the last completed frame saw two or more keys.

## Operation
- **Row synchroniser:** two flops per row bit; all row logic uses only the synchronised value.
- **Scan:** slot counter runs 0..SCAN_DIV-1; column index runs 0..COLS-1 and wraps to 0. `col` = ~(1<<col_idx).
- **Sampling:** at slot count SCAN_DIV-1 the synchronised row is sampled for the current column, and the column then advances.
- **Frame accumulation:** over one frame, count the low row bits and record the (row, col) of the lowest-indexed hit.
- **Frame classification** after column COLS-1 is sampled: NONE (0 hits), SINGLE(code) (exactly 1 hit), MULTI (2 or more hits).
- **FSM states:** RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND. It moves only at frame-end. Debounce counter width is $clog2(DEBOUNCE+1).
  - RELEASED: SINGLE -> PRESS_PEND, cand=code, cnt=1. Other results -> stay.
  - PRESS_PEND: SINGLE with cand -> cnt+1. SINGLE with another code -> cand=new code, cnt=1. NONE or MULTI -> RELEASED.
  - Press accept: when cnt reaches DEBOUNCE -> PRESSED, latch cand into the key outputs, pulse `key_press`.
  - PRESSED: SINGLE with the latched code -> stay. Any other result -> RELEASE_PEND, cnt=1.
  - RELEASE_PEND: SINGLE with the latched code -> PRESSED, no pulse (bounce). Any other result -> cnt+1.
  - Release accept: when cnt reaches DEBOUNCE -> RELEASED, pulse `key_release`.
  - DEBOUNCE=1: accept on the first qualifying frame, going RELEASED->PRESSED and PRESSED->RELEASED directly.
- **Rollover:** moving directly from one key to another yields a release of the old key, then a separate press of the new one. There is never a press without an intervening release.
- **Key outputs:** `key_code`, `key_row` and `key_col` hold their value from the press accept through the release and until the next press.
- **multi_key:** updated every frame-end.

## Timing
- Frame length is COLS*SCAN_DIV cycles.
- Row-to-sample latency is 2 cycles (synchroniser); the column has settled SCAN_DIV-1 cycles before its sample.
- Frame-end decision is registered 1 cycle after the last sample. `key_press`, `key_release` and `multi_key` change on that edge.
- Minimum press latency is DEBOUNCE frames from the first frame containing the key. Release latency is the same.
- **Reset values:** `col`=~1 (column 0 active), slot=0, col_idx=0, state RELEASED, all counters 0, `key_code`/`key_row`/`key_col`=0, `key_press`/`key_release`/`key_held`/`multi_key`=0, synchroniser flops all ones.
- **Reset mid-press:** return to RELEASED with no `key_release` pulse. The still-held key is re-detected after DEBOUNCE frames.
- `key_press` and `key_release` never assert in the same cycle.

## Structure
- Package `keypad_pkg`: FSM state enum (`kp_state_t`), frame-result enum (`kp_frame_t`: NONE, SINGLE, MULTI), and a code-width function for CW.
- Sub-module `keypad_debounce_fsm`: takes the frame-end strobe, frame class and code; produces the press/release pulses, held status and latched code.
- Top level: synchroniser, scan counters and frame accumulator.

## Test plan
All scenarios use ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3 (32-cycle frame).
- **Single press:** after reset, hold row 2 low while column 1 is driven, for 5 frames -> exactly one `key_press` at the end of frame 3 with `key_code`=9, `key_row`=2, `key_col`=1, and `key_held`=1.
- **Press bounce:** key 9 present for 2 frames, absent 1 frame, then present 3 frames -> a single `key_press`, at the end of the 6th frame.
- **Release debounce:** release key 9, re-assert it for 1 frame, then release -> no spurious events; one `key_release` 3 frames after the final release; `key_code` stays 9.
- **Multi-key:** hold keys 0 and 5 together -> `multi_key`=1 after the first frame and no `key_press`; drop key 5 -> press of code 0 after 3 frames and `multi_key`=0.
- **Rollover:** go from key 3 directly to key 12 -> `key_release` for 3, then `key_press` for 12 three frames later, never in the same cycle.
- **Reset mid-operation:** assert `rst` while key 9 is held -> all outputs 0 next cycle, `col`=4'b1110, no `key_release`; `key_press`(9) re-fires 3 frames after `rst` deasserts.
